cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Synthesizable on-chip trace capture for the single-cycle RV32 core. It records per-cycle execution state (PC, instruction, rs1 access, ALU result, cycle stamp) into a circular buffer of parametrised depth. Capture stops a programmable number of samples after a PC-match trigger, and the window is then drained oldest-first over a valid/ready port. It sits beside the core's datapath taps, replaces simulation-only console logging on silicon/FPGA, and feeds a debug/UART bridge.

## Interface
- DEPTH, 16, buffer entries; power of two, ≥ 2
- XLEN, 32, datapath width of PC/instr/data fields
- POST_TRIG, 4, samples captured after the trigger sample; 0 ≤ POST_TRIG < DEPTH
- STAMP_W, 16, cycle-stamp width
- i_clock  in  1  clock
- i_resetn  in  1  reset, asynchronous, active-low
- i_arm  in  1  start capture (honoured in IDLE only)
- i_stop  in  1  force end of capture, go to readout
- i_trig_en  in  1  enable PC-match trigger
- i_trig_pc  in  XLEN  trigger PC value
- i_valid  in  1  current-cycle core state is a retired instruction
- i_PC, i_instr, i_rs1Data, i_result  in  XLEN each  core taps
- i_rs1Addr  in  5  rs1 register index
- o_rd_valid  out  1  readout entry present
- i_rd_ready  in  1  consumer accepts entry
- o_rd_pc, o_rd_instr, o_rd_rs1Data, o_rd_result  out  XLEN each  entry fields
- o_rd_rs1Addr  out  5  entry field
- o_rd_stamp  out  STAMP_W  cycle stamp of entry
- o_state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 READOUT
- o_count  out  $clog2(DEPTH)+1  entries held / remaining to read

## Operation
- Stamp counter: free-running STAMP_W-bit, increments every clock, wraps to 0; each written entry stores its current value.
- IDLE: no writes. i_arm → CAPTURE; fill count, write pointer, post counter cleared on that edge.
- CAPTURE: every i_valid cycle writes entry at wr_ptr, wr_ptr+1 mod DEPTH, fill saturates at DEPTH (oldest overwritten). Trigger = i_trig_en & i_valid & (i_PC == i_trig_pc); the trigger sample is written, then → POST, or → READOUT if POST_TRIG = 0.
- POST: each i_valid sample is written, post counter +1; the write that makes it POST_TRIG → READOUT. Further triggers ignored.
- i_stop in CAPTURE/POST → READOUT; the same-cycle i_valid sample is still written. i_stop wins over a same-cycle trigger.
- READOUT: read pointer starts at (wr_ptr − fill) mod DEPTH; o_rd_* driven combinationally from the entry at the read pointer; o_rd_valid = (remaining ≠ 0). Handshake (valid & ready) advances pointer, decrements remaining. remaining = 0 → IDLE. No writes; i_arm, i_trig_* ignored.
- o_count = fill in CAPTURE/POST, remaining in READOUT, 0 in IDLE.
- i_arm outside IDLE: ignored.

## Timing
- Reset (async assert): o_state = IDLE, o_rd_valid = 0, o_count = 0, stamp = 0, all pointers/counters 0; o_rd_* data fields = 0. Buffer contents need no reset.
- Arm: state CAPTURE on the edge where i_arm is sampled; first write possible on the following edge.
- Entry becomes READOUT-visible the cycle after the final write; o_rd_valid asserts in the first READOUT cycle.
- Backpressure: o_rd_* stable while o_rd_valid & !i_rd_ready.
- Throughput: one entry per cycle with i_rd_ready held high.
- Empty readout (stop with fill 0): one READOUT cycle, o_rd_valid never asserts, then IDLE.
- Last handshake: o_rd_valid low and IDLE on the next cycle.
- Reset mid-operation: immediate IDLE, o_rd_valid drops asynchronously; the captured window is lost.

## Test plan
- Reset with i_arm/i_valid toggling → o_state = 0, o_rd_valid = 0, o_count = 0 until release; stamp counts 0, 1, 2… after release.
- DEPTH = 8, POST_TRIG = 3, arm, i_valid every cycle, PC = 4·i, trig_pc = 0x10 → trigger at i = 4, captures i = 0..7, readout PCs 0x00..0x1C in order, stamps consecutive, then IDLE.
- Same config, trig_pc = 0x50, PC = 4·i for i = 0..23 → wrap; readout exactly 8 entries, PCs 0x40..0x5C, o_count 8 → 0.
- Readout with i_rd_ready low for 3 cycles → o_rd_pc holds 0x40; ready high → one entry per cycle; i_valid gaps during POST extend capture with no missing/duplicate entries.
- i_stop after 2 samples (PC 0x0, 0x4) → readout of 2 entries. i_stop with 0 samples → no o_rd_valid, IDLE after 1 cycle. Trigger and i_stop in the same cycle → READOUT, sample written, no POST.
- Assert i_resetn low in POST and again mid-readout → o_state = 0, o_rd_valid = 0 immediately; re-arm captures correctly afterwards.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_trace_buffer_if : trace readout stream (valid/ready plus entry fields)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cpu_trace_buffer_if #(
    parameter int XLEN    = 32,
    parameter int STAMP_W = 16
);
    logic               o_rd_valid;
    logic               i_rd_ready;
    logic [XLEN-1:0]    o_rd_pc;
    logic [XLEN-1:0]    o_rd_instr;
    logic [XLEN-1:0]    o_rd_rs1Data;
    logic [XLEN-1:0]    o_rd_result;
    logic [4:0]         o_rd_rs1Addr;
    logic [STAMP_W-1:0] o_rd_stamp;

    modport master (
        output o_rd_valid, o_rd_pc, o_rd_instr, o_rd_rs1Data, o_rd_result,
               o_rd_rs1Addr, o_rd_stamp,
        input  i_rd_ready
    );

    modport slave (
        input  o_rd_valid, o_rd_pc, o_rd_instr, o_rd_rs1Data, o_rd_result,
               o_rd_rs1Addr, o_rd_stamp,
        output i_rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_trace_buffer : circular per-cycle trace capture with PC trigger and
//                    oldest-first valid/ready readout
// Revision: 1.0
// ---------------------------------------------------------------------------
module cpu_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 32,
    parameter int POST_TRIG = 4,
    parameter int STAMP_W   = 16
) (
    input  wire logic                   i_clock,
    input  wire logic                   i_resetn,
    input  wire logic                   i_arm,
    input  wire logic                   i_stop,
    input  wire logic                   i_trig_en,
    input  wire logic [XLEN-1:0]        i_trig_pc,
    input  wire logic                   i_valid,
    input  wire logic [XLEN-1:0]        i_PC,
    input  wire logic [XLEN-1:0]        i_instr,
    input  wire logic [XLEN-1:0]        i_rs1Data,
    input  wire logic [XLEN-1:0]        i_result,
    input  wire logic [4:0]             i_rs1Addr,
    cpu_trace_buffer_if.master          rd,
    output logic [1:0]                  o_state,
    output logic [$clog2(DEPTH):0]      o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    instr;
        logic [XLEN-1:0]    rs1Data;
        logic [XLEN-1:0]    result;
        logic [4:0]         rs1Addr;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    entry_t             mem_q [DEPTH];

    state_t             state_q, state_d;
    logic [STAMP_W-1:0] stamp_q;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fill_q, fill_d;
    logic [CW-1:0]      post_q, post_d;
    logic [CW-1:0]      remain_q, remain_d;
    logic               write_en;
    logic               go_readout;
    logic               trig_hit;
    logic               rd_valid;
    entry_t             rd_entry;

    assign trig_hit = i_trig_en & i_valid & (i_PC == i_trig_pc);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        post_d     = post_q;
        remain_d   = remain_q;
        write_en   = 1'b0;
        go_readout = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_arm) begin
                    state_d  = S_CAPTURE;
                    fill_d   = '0;
                    wr_ptr_d = '0;
                    post_d   = '0;
                end
            end

            S_CAPTURE, S_POST: begin
                if (i_valid) begin
                    write_en = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (fill_q != CW'(DEPTH)) begin
                        fill_d = fill_q + CW'(1);
                    end
                end

                // Stop has priority over a trigger seen in the same cycle.
                if (i_stop) begin
                    go_readout = 1'b1;
                end else if (state_q == S_CAPTURE && trig_hit) begin
                    if (POST_TRIG == 0) begin
                        go_readout = 1'b1;
                    end else begin
                        state_d = S_POST;
                    end
                end else if (state_q == S_POST && i_valid) begin
                    post_d = post_q + CW'(1);
                    if (post_q + CW'(1) == CW'(POST_TRIG)) begin
                        go_readout = 1'b1;
                    end
                end

                // Oldest entry sits fill positions behind the post-write pointer.
                if (go_readout) begin
                    state_d  = S_READOUT;
                    remain_d = fill_d;
                    rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
                end
            end

            S_READOUT: begin
                if (remain_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd.i_rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    remain_d = remain_q - CW'(1);
                    if (remain_q == CW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q  <= S_IDLE;
            stamp_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            post_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            stamp_q  <= stamp_q + STAMP_W'(1);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            post_q   <= post_d;
            remain_q <= remain_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= {i_PC, i_instr, i_rs1Data, i_result, i_rs1Addr, stamp_q};
        end
    end

    // Data fields are gated so they read zero whenever no entry is offered.
    assign rd_valid        = (state_q == S_READOUT) && (remain_q != '0);
    assign rd_entry        = mem_q[rd_ptr_q];
    assign rd.o_rd_valid   = rd_valid;
    assign rd.o_rd_pc      = rd_valid ? rd_entry.pc      : '0;
    assign rd.o_rd_instr   = rd_valid ? rd_entry.instr   : '0;
    assign rd.o_rd_rs1Data = rd_valid ? rd_entry.rs1Data : '0;
    assign rd.o_rd_result  = rd_valid ? rd_entry.result  : '0;
    assign rd.o_rd_rs1Addr = rd_valid ? rd_entry.rs1Addr : '0;
    assign rd.o_rd_stamp   = rd_valid ? rd_entry.stamp   : '0;

    assign o_state = state_q;

    always_comb begin
        case (state_q)
            S_CAPTURE, S_POST: o_count = fill_q;
            S_READOUT:         o_count = remain_q;
            default:           o_count = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_trace_buffer : vector table plus scoreboard bench for cpu_trace_buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cpu_trace_buffer;
    localparam int DEPTH     = 8;
    localparam int XLEN      = 32;
    localparam int POST_TRIG = 3;
    localparam int STAMP_W   = 16;

    logic              i_clock = 1'b0;
    logic              i_resetn = 1'b0;
    logic              i_arm = 1'b0;
    logic              i_stop = 1'b0;
    logic              i_trig_en = 1'b0;
    logic [XLEN-1:0]   i_trig_pc = '0;
    logic              i_valid = 1'b0;
    logic [XLEN-1:0]   i_PC = '0;
    logic [XLEN-1:0]   i_instr = '0;
    logic [XLEN-1:0]   i_rs1Data = '0;
    logic [XLEN-1:0]   i_result = '0;
    logic [4:0]        i_rs1Addr = '0;
    logic [1:0]        o_state;
    logic [3:0]        o_count;

    cpu_trace_buffer_if #(.XLEN(XLEN), .STAMP_W(STAMP_W)) rd_if ();

    cpu_trace_buffer #(
        .DEPTH(DEPTH), .XLEN(XLEN), .POST_TRIG(POST_TRIG), .STAMP_W(STAMP_W)
    ) dut (
        .i_clock(i_clock), .i_resetn(i_resetn), .i_arm(i_arm), .i_stop(i_stop),
        .i_trig_en(i_trig_en), .i_trig_pc(i_trig_pc), .i_valid(i_valid),
        .i_PC(i_PC), .i_instr(i_instr), .i_rs1Data(i_rs1Data),
        .i_result(i_result), .i_rs1Addr(i_rs1Addr), .rd(rd_if),
        .o_state(o_state), .o_count(o_count)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [31:0] pc, instr, rs1d, res;
        logic [4:0]  ra;
        logic [15:0] stamp;
    } ent_t;

    typedef struct {
        logic        arm, valid, stop;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [3:0]  cnt;
    } vec_t;

    ent_t        exp_q[$];
    vec_t        tbl[9];
    int          checks = 0;
    int          errors = 0;
    int          mst = 0;
    int          mpost = 0;
    logic [15:0] tb_stamp = '0;

    function automatic ent_t mk(input logic [31:0] pc, input logic [15:0] st);
        ent_t e;
        e.pc    = pc;
        e.instr = {pc[15:0], 16'h0093};
        e.rs1d  = ~pc;
        e.res   = pc * 3 + 1;
        e.ra    = pc[6:2];
        e.stamp = st;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
        if (i_resetn) tb_stamp++;
    endtask

    // Drive one cycle of stimulus and advance the reference capture model.
    task automatic drive(input logic arm, input logic valid, input logic [31:0] pc,
                         input logic stop, input logic ten, input logic [31:0] tpc);
        ent_t e;
        logic trig;
        e = mk(pc, tb_stamp);
        i_arm = arm; i_valid = valid; i_stop = stop; i_trig_en = ten; i_trig_pc = tpc;
        i_PC = pc; i_instr = e.instr; i_rs1Data = e.rs1d; i_result = e.res; i_rs1Addr = e.ra;
        trig = ten && valid && (pc == tpc);
        if (mst == 0) begin
            if (arm) begin
                mst = 1; mpost = 0; exp_q.delete();
            end
        end else if (mst == 1 || mst == 2) begin
            if (valid) begin
                exp_q.push_back(e);
                if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            end
            if (stop) mst = 3;
            else if (mst == 1 && trig) mst = (POST_TRIG == 0) ? 3 : 2;
            else if (mst == 2 && valid) begin
                mpost++;
                if (mpost == POST_TRIG) mst = 3;
            end
        end
        step();
        i_arm = 1'b0; i_valid = 1'b0; i_stop = 1'b0;
    endtask

    task automatic check_ctl(input string name);
        check({name, " state"}, o_state, mst);
        check({name, " count"}, o_count, (mst == 0) ? 0 : exp_q.size());
    endtask

    task automatic drain(input int stalls);
        int guard;
        int st;
        guard = 0;
        st = stalls;
        if (exp_q.size() == 0) begin
            check("empty ro state", o_state, 3);
            check("empty ro valid", rd_if.o_rd_valid, 0);
            step();
        end else begin
            while (exp_q.size() > 0 && guard < 64) begin
                check("ro valid", rd_if.o_rd_valid, 1);
                check("ro count", o_count, exp_q.size());
                if (st > 0) begin
                    rd_if.i_rd_ready = 1'b0;
                    check("ro hold pc", rd_if.o_rd_pc, exp_q[0].pc);
                    st--;
                    step();
                end else begin
                    rd_if.i_rd_ready = 1'b1;
                    check("ro pc", rd_if.o_rd_pc, exp_q[0].pc);
                    check("ro stamp", rd_if.o_rd_stamp, exp_q[0].stamp);
                    check("ro fields", {rd_if.o_rd_instr, rd_if.o_rd_rs1Data},
                          {exp_q[0].instr, exp_q[0].rs1d});
                    check("ro result/addr", {rd_if.o_rd_result, rd_if.o_rd_rs1Addr},
                          {exp_q[0].res, exp_q[0].ra});
                    step();
                    void'(exp_q.pop_front());
                end
                guard++;
            end
            check("drain bound", exp_q.size(), 0);
        end
        rd_if.i_rd_ready = 1'b0;
        mst = 0;
        check("post-drain state", o_state, 0);
        check("post-drain valid", rd_if.o_rd_valid, 0);
    endtask

    task automatic assert_reset(input string name);
        i_resetn = 1'b0;
        #1;
        check({name, " async state"}, o_state, 0);
        check({name, " async valid"}, rd_if.o_rd_valid, 0);
        check({name, " async count"}, o_count, 0);
        check({name, " async pc"}, rd_if.o_rd_pc, 0);
        mst = 0; mpost = 0; exp_q.delete();
        rd_if.i_rd_ready = 1'b0;
        tb_stamp = '0;
        i_resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // arm, valid, stop, pc, expected state, expected count
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h00, 2'd1, 4'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h00, 2'd1, 4'd1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h04, 2'd1, 4'd2};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h08, 2'd1, 4'd3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0C, 2'd1, 4'd4};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 4'd5};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h14, 2'd2, 4'd6};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h18, 2'd2, 4'd7};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h1C, 2'd3, 4'd8};
        rd_if.i_rd_ready = 1'b0;

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            i_arm = i[0]; i_valid = ~i[0];
            step();
            check("reset state", o_state, 0);
            check("reset valid", rd_if.o_rd_valid, 0);
            check("reset count", o_count, 0);
        end
        i_arm = 1'b0; i_valid = 1'b0;
        tb_stamp = '0;
        i_resetn = 1'b1;

        // Trigger at PC 0x10 with three post samples
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].arm, tbl[k].valid, tbl[k].pc, tbl[k].stop, 1'b1, 32'h10);
            check("tbl state", o_state, tbl[k].st);
            check("tbl count", o_count, tbl[k].cnt);
        end
        check("first stamp", rd_if.o_rd_stamp, 1);
        drain(0);

        // Wrap-around with valid gaps during POST and backpressure
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h50);
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b1, 32'(4 * i), 1'b0, 1'b1, 32'h50);
            if (i >= 20 && i < 23) drive(1'b0, 1'b0, 32'hDEAD_0000, 1'b0, 1'b1, 32'h50);
        end
        check("wrap state", o_state, 3);
        check("wrap count", o_count, 8);
        check("wrap oldest pc", rd_if.o_rd_pc, 32'h40);
        drain(3);

        // Stop after two samples
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h8, 1'b1, 1'b0, 32'h0);
        check("stop2 state", o_state, 3);
        check("stop2 count", o_count, 2);
        drain(0);

        // Stop with no samples
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_ctl("stop0");
        drain(0);

        // Trigger and stop in the same cycle
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h10);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10);
        check("trigstop state", o_state, 3);
        check("trigstop count", o_count, 2);
        drain(1);

        // Reset during POST
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h4);
        drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b1, 32'h4);
        drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 32'h4);
        check("post state", o_state, 2);
        assert_reset("rst post");

        // Reset in the middle of readout
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0);
        check_ctl("midro");
        check("midro pc", rd_if.o_rd_pc, 32'h100);
        rd_if.i_rd_ready = 1'b1;
        step();
        void'(exp_q.pop_front());
        rd_if.i_rd_ready = 1'b0;
        check_ctl("midro after hs");
        check("midro next pc", rd_if.o_rd_pc, 32'h104);
        assert_reset("rst ro");

        // Re-arm after reset
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h208, 1'b1, 1'b0, 32'h0);
        check("rearm state", o_state, 3);
        check("rearm count", o_count, 3);
        check("rearm stamp", rd_if.o_rd_stamp, 1);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
